// File: rtl/ad9958_cmd_framer.sv
// AD9958 command framer: turns register writes into instruction+data SPI frames, runs the serializer
// trigger/busy handshake, then optional IO_UPDATE and idle gap. Optional trigger timeout: AD9958_CMD_FRAMER_TIMEOUT_EN.
module ad9958_cmd_framer #(
    parameter int IOUPD_WIDTH    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_update,
    output logic        spi_trigger,
    output logic [4:0]  spi_packs,
    output logic [63:0] spi_data,
    input  logic        spi_busy,
    output logic        io_update,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_DONE, IOUPD, GAP} state_t;

    // With a zero gap the post-frame/post-update target is IDLE directly.
    localparam state_t     POST_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;
    localparam logic [7:0] GAP_LD     = 8'(GAP_CYCLES);
    localparam logic [7:0] IOUPD_LD   = 8'(IOUPD_WIDTH);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        upd, upd_nxt;
    logic [63:0] spi_data_nxt;
    logic [4:0]  spi_packs_nxt;
    logic        err_nxt;

    logic [2:0]  len;
    logic [7:0]  instr;
    logic [63:0] frame;

`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
    localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt, tcnt_nxt;
`endif

    // Register data length in bytes; 0 marks an unimplemented address.
    always_comb begin
        len = 3'd0;
        case (cmd_addr)
            5'h00:               len = 3'd1;
            5'h01, 5'h03, 5'h06: len = 3'd3;
            5'h02, 5'h05, 5'h07: len = 3'd2;
            default:             len = (cmd_addr <= 5'h18) ? 3'd4 : 3'd0;
        endcase
    end

    always_comb begin
        instr = {3'b000, cmd_addr};
        frame = '0;
        case (len)
            3'd1:    frame = {48'd0, instr, cmd_data[7:0]};
            3'd2:    frame = {40'd0, instr, cmd_data[15:0]};
            3'd3:    frame = {32'd0, instr, cmd_data[23:0]};
            3'd4:    frame = {24'd0, instr, cmd_data};
            default: frame = '0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        upd_nxt       = upd;
        spi_data_nxt  = spi_data;
        spi_packs_nxt = spi_packs;
        err_nxt       = 1'b0;
`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
        tcnt_nxt      = tcnt;
`endif
        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        spi_trigger = (state == TRIG);
        io_update   = (state == IOUPD);

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (len == 3'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        spi_data_nxt  = frame;
                        spi_packs_nxt = {1'b0, len, 1'b0} + 5'd2;
                        upd_nxt       = cmd_update;
                        state_nxt     = TRIG;
`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
                        tcnt_nxt      = '0;
`endif
                    end
                end
            end
            TRIG: begin
                if (spi_busy) begin
                    state_nxt = WAIT_DONE;
                end
`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
                else if (tcnt == TMAX) begin
                    err_nxt   = 1'b1;
                    state_nxt = POST_STATE;
                    cnt_nxt   = GAP_LD;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!spi_busy) begin
                    if (upd) begin
                        state_nxt = IOUPD;
                        cnt_nxt   = IOUPD_LD;
                    end else begin
                        state_nxt = POST_STATE;
                        cnt_nxt   = GAP_LD;
                    end
                end
            end
            IOUPD: begin
                if (cnt == 8'd1) begin
                    state_nxt = POST_STATE;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd1) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            upd       <= 1'b0;
            spi_data  <= '0;
            spi_packs <= '0;
            err       <= 1'b0;
`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            upd       <= upd_nxt;
            spi_data  <= spi_data_nxt;
            spi_packs <= spi_packs_nxt;
            err       <= err_nxt;
`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
            tcnt      <= tcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ad9958_cmd_framer.sv
// Randomized bench for ad9958_cmd_framer: serializer model plus frame/timing reference derived from
// the register-length table; also covers invalid addresses, back-to-back commands, mid-frame reset, timeout.
module tb_ad9958_cmd_framer;

    localparam int IOUPD_W = 4;
    localparam int GAP_C   = 2;
    localparam int TMO     = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_update;
    logic        spi_trigger;
    logic [4:0]  spi_packs;
    logic [63:0] spi_data;
    logic        spi_busy;
    logic        io_update;
    logic        busy;
    logic        err;

    always #5 clock = ~clock;

    ad9958_cmd_framer #(
        .IOUPD_WIDTH(IOUPD_W),
        .GAP_CYCLES(GAP_C),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .cmd_update(cmd_update),
        .spi_trigger(spi_trigger),
        .spi_packs(spi_packs),
        .spi_data(spi_data),
        .spi_busy(spi_busy),
        .io_update(io_update),
        .busy(busy),
        .err(err)
    );

    typedef struct {
        int          a;
        logic [31:0] d;
        bit          u;
        bit          hold;
        int          dly;
        int          blen;
    } cmd_t;

    cmd_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_len(input int a);
        if (a == 0) return 1;
        if (a == 1 || a == 3 || a == 6) return 3;
        if (a == 2 || a == 5 || a == 7) return 2;
        if (a == 4 || (a >= 8 && a <= 24)) return 4;
        return 0;
    endfunction

    function automatic logic [63:0] ref_frame(input int a, input logic [31:0] d);
        int          len;
        logic [63:0] mask;
        len  = ref_len(a);
        mask = (64'd1 << (8 * len)) - 64'd1;
        return (64'(a) << (8 * len)) | ({32'd0, d} & mask);
    endfunction

    task automatic add(input int a, input logic [31:0] d, input bit u, input bit hold, input int dly, input int blen);
        cmd_t c;
        c.a = a; c.d = d; c.u = u; c.hold = hold; c.dly = dly; c.blen = blen;
        q.push_back(c);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_trig"}, spi_trigger, 0);
        chk({tag, "_packs"}, spi_packs, 0);
        chk({tag, "_data"}, spi_data, 0);
        chk({tag, "_io"}, io_update, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Entered and left just after a falling edge.
    task automatic run_cmd(input int i);
        cmd_t        c;
        int          len, trig_hi, low_cnt, io_cnt, exp_io;
        logic [63:0] ef;
        bit          bad, bad2, io_ok, done;
        c   = q[i];
        len = ref_len(c.a);
        ef  = ref_frame(c.a, c.d);
        cmd_valid  = 1'b1;
        cmd_addr   = 5'(c.a);
        cmd_data   = c.d;
        cmd_update = c.u;
        chk("ready_before", cmd_ready, 1);
        @(negedge clock);
        if (len == 0) begin
            cmd_valid = 1'b0;
            chk("inv_err", err, 1);
            chk("inv_ready", cmd_ready, 1);
            chk("inv_trig", spi_trigger, 0);
            @(negedge clock);
            chk("inv_err_clr", err, 0);
            chk("inv_trig2", spi_trigger, 0);
            chk("inv_busy", busy, 0);
            return;
        end
        if (c.hold && i + 1 < q.size()) begin
            cmd_addr   = 5'(q[i+1].a);
            cmd_data   = q[i+1].d;
            cmd_update = q[i+1].u;
        end else begin
            cmd_valid = 1'b0;
        end
        chk("packs", spi_packs, 64'(2 * (len + 1)));
        chk("data", spi_data, ef);
        chk("ready_low", cmd_ready, 0);
        chk("busy_hi", busy, 1);
        trig_hi = 0;
        repeat (c.dly) begin
            if (spi_trigger) trig_hi++;
            @(negedge clock);
        end
        if (spi_trigger) trig_hi++;
        spi_busy = 1'b1;
        @(negedge clock);
        chk("trig_len", trig_hi, 64'(c.dly + 1));
        chk("trig_drop", spi_trigger, 0);
        bad = 1'b0;
        for (int k = 0; k < c.blen - 1; k++) begin
            if (spi_trigger || io_update || cmd_ready || err || spi_data !== ef) bad = 1'b1;
            @(negedge clock);
        end
        if (spi_trigger || io_update || cmd_ready || err || spi_data !== ef) bad = 1'b1;
        chk("busy_phase", bad, 0);
        spi_busy = 1'b0;
        low_cnt = 0; io_cnt = 0; io_ok = 1'b1; bad2 = 1'b0; done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clock);
            if (cmd_ready) begin
                done = 1'b1;
            end else begin
                low_cnt++;
                if (io_update) begin
                    io_cnt++;
                    if (io_cnt != low_cnt) io_ok = 1'b0;
                end
                if (spi_trigger || err || spi_data !== ef) bad2 = 1'b1;
            end
        end
        exp_io = c.u ? IOUPD_W : 0;
        chk("done", done, 1);
        chk("ready_gap", low_cnt, 64'(exp_io + GAP_C));
        chk("io_len", io_cnt, 64'(exp_io));
        chk("io_start", io_ok, 1);
        chk("tail", bad2, 0);
        chk("idle_hold", spi_data, ef);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int lc;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        cmd_update = 1'b0;
        spi_busy   = 1'b0;
        repeat (2) @(negedge clock);
        chk_rst("rst");
        reset = 1'b0;
        @(negedge clock);
        chk_rst("post_rst");

        add(5'h04, 32'h1234_5678, 1'b0, 1'b0, 1, 12);
        add(5'h00, 32'hFFFF_FFF0, 1'b0, 1'b0, 0, 5);
        add(5'h01, 32'hAABB_CCDD, 1'b0, 1'b0, 2, 3);
        add(5'h02, 32'h0000_1234, 1'b1, 1'b0, 1, 6);
        add(5'h19, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1);
        add(5'h08, $urandom, 1'b0, 1'b1, 1, 4);
        add(5'h09, $urandom, 1'b1, 1'b0, 0, 2);
        for (int n = 0; n < 25; n++) begin
            add(($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(0, 24)),
                $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 15)));
        end
        for (int i = 0; i < q.size(); i++) run_cmd(i);

        // Reset while the serializer is busy.
        cmd_valid = 1'b1; cmd_addr = 5'h04; cmd_data = $urandom; cmd_update = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        spi_busy  = 1'b1;
        repeat (2) @(negedge clock);
        chk("wd_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_rst("rst_wd");
        spi_busy = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset in the middle of the IO_UPDATE pulse.
        cmd_valid = 1'b1; cmd_addr = 5'h02; cmd_data = $urandom; cmd_update = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        spi_busy  = 1'b1;
        @(negedge clock);
        spi_busy = 1'b0;
        repeat (2) @(negedge clock);
        chk("iou_hi", io_update, 1);
        #2 reset = 1'b1;
        #1 chk_rst("rst_iou");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

`ifdef AD9958_CMD_FRAMER_TIMEOUT_EN
        spi_busy  = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 5'h04; cmd_data = $urandom; cmd_update = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        lc = 0;
        while (spi_trigger && lc < 3000) begin
            lc++;
            @(negedge clock);
        end
        chk("tmo_len", lc, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_io", io_update, 0);
        chk("tmo_ready", cmd_ready, 0);
        lc = 1;
        @(negedge clock);
        chk("tmo_err_clr", err, 0);
        while (!cmd_ready && lc < 100) begin
            lc++;
            @(negedge clock);
        end
        chk("tmo_gap", lc, GAP_C);
`endif
        lc = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9958_cmd_framer.md
Name: ad9958_cmd_framer

Overview:
- Upstream stage of the 4-bit SPI serializer for the AD9958 DDS.
- Accepts register-write commands (address plus up to 32 data bits) over a valid/ready handshake.
- Builds the AD9958 serial frame (instruction byte followed by register-width data) and sets the nibble count.
- Drives the serializer's trigger/busy handshake, then optionally pulses IO_UPDATE so the write takes effect.

Parameters:
IOUPD_WIDTH, 4, io_update high time in clock cycles (1..255)
GAP_CYCLES, 2, idle cycles after each frame or IO_UPDATE before cmd_ready returns (0..255)
TIMEOUT_CYCLES, 1024, clocks allowed for spi_busy to rise after trigger (only with macro)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_addr  in  5  AD9958 register address
cmd_data  in  32  register value, right-aligned
cmd_update  in  1  pulse io_update after this frame
spi_trigger  out  1  start request to serializer
spi_packs  out  5  frame length in nibbles
spi_data  out  64  frame, right-aligned, MSB nibble sent first
spi_busy  in  1  serializer busy
io_update  out  1  AD9958 IO_UPDATE pin
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle error pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: cmd_ready=1, spi_trigger=0, spi_packs=0, spi_data=0, io_update=0, busy=0, err=0, state=IDLE.
- Register byte lengths (len):
  - 0x00 CSR: 1
  - 0x01 FR1, 0x03 CFR, 0x06 ACR: 3
  - 0x02 FR2, 0x05 CPOW0, 0x07 LSRR: 2
  - 0x04 CFTW0, 0x08 RDW, 0x09 FDW, 0x0A-0x18 CW1-CW15: 4
  - 0x19-0x1F: invalid.
- Frame format:
  - Instruction byte = {1'b0 write, 2'b00, addr}.
  - spi_packs = 2*(len+1).
  - spi_data[8*len+7 : 8*len] = instruction byte; spi_data[8*len-1:0] = cmd_data[8*len-1:0].
  - All higher spi_data bits are 0; unused cmd_data bits are ignored.
- IDLE:
  - cmd_ready=1. Accept on cmd_valid & cmd_ready.
  - Valid address: spi_data/spi_packs registered on the accept edge; go to TRIG; cmd_ready=0 from the next cycle.
  - Invalid address: err=1 for the next cycle only, nothing sent, remain IDLE, cmd_ready stays 1.
- TRIG:
  - spi_trigger=1, held until spi_busy is sampled high; then go to WAIT_DONE with spi_trigger=0 from the next cycle.
- WAIT_DONE:
  - Wait for spi_busy=0.
  - Then go to IOUPD if the latched cmd_update=1, else to GAP.
- IOUPD: io_update=1 for exactly IOUPD_WIDTH cycles, then go to GAP.
- GAP: GAP_CYCLES cycles (0 means skip directly), then go to IDLE.
- spi_data and spi_packs hold stable from TRIG entry until the next accept; the serializer samples them during its whole busy period.
- spi_trigger is never high while the state is WAIT_DONE, so the serializer cannot retrigger when it returns to idle.
- spi_busy already high on TRIG entry: counts as the acknowledge; the frame is considered started.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); io_update is cut short. No recovery of the serializer is attempted; it has its own reset.
- Counters are 8-bit for IOUPD/GAP and clog2(TIMEOUT_CYCLES+1) bits for the timeout. None wrap; each reloads on state entry.

Optional Feature:
- Macro AD9958_CMD_FRAMER_TIMEOUT_EN.
- Defined:
  - TRIG counts cycles. If spi_busy is not seen within TIMEOUT_CYCLES, drop spi_trigger, pulse err for 1 cycle and go to GAP (no io_update).
  - WAIT_DONE has no timeout.
- Undefined: TRIG waits indefinitely; err is driven only by invalid addresses.

Test Plan:
- addr=0x04, data=0x12345678, update=0; serializer model raises busy 1 cycle after trigger and holds it 12 cycles -> spi_packs=10, spi_data=64'h0000_0004_1234_5678; trigger high exactly until busy is seen; io_update stays 0; cmd_ready returns GAP_CYCLES(2) cycles after busy falls.
- addr=0x00, data=0xFFFF_FFF0 -> spi_packs=4, spi_data=64'h00F0. addr=0x01, data=0xAABBCCDD -> spi_packs=8, spi_data=64'h01BB_CCDD.
- addr=0x02, data=0x1234, update=1 -> spi_packs=6, spi_data=64'h02_1234; io_update high exactly 4 cycles starting the cycle after busy falls, then 2 gap cycles, then cmd_ready=1.
- addr=0x19, cmd_valid for 1 cycle -> err high 1 cycle, spi_trigger never asserted, cmd_ready stays 1.
- Back-to-back: cmd_valid held with two commands -> second accepted only after the GAP of the first; no trigger overlap with busy.
- Reset asserted during WAIT_DONE and during IOUPD -> outputs return to reset values asynchronously. With the macro and spi_busy tied 0: err pulses after 1024 trigger cycles and cmd_ready returns after GAP.
